// File: rtl/mem_access_if.sv
// MEM-stage bus: EX-side request/bundle inputs plus the registered MEM/WB bundle and busy/error status.
// Carries mem_size/load_unsigned only when DM_SUBWORD_ACCESS_EN is defined.
interface mem_access_if;
    logic        stall_flag_mem_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_in_mem;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic        mem_read;
    logic        mem_write;
`ifdef DM_SUBWORD_ACCESS_EN
    logic [1:0]  mem_size;
    logic        load_unsigned;
`endif
    logic [31:0] alu_data_out;
    logic [31:0] dm_data_out;
    logic [4:0]  rd_out_mem;
    logic        reg_write_out_mem;
    logic        mem_to_reg_out;
    logic        stall_flag_mem_out;
    logic        mem_busy;
    logic        addr_err;

    modport slave (
`ifdef DM_SUBWORD_ACCESS_EN
        input  mem_size, load_unsigned,
`endif
        input  stall_flag_mem_in, alu_result_in, store_data_in, rd_in_mem,
        input  reg_write_in, mem_to_reg_in, mem_read, mem_write,
        output alu_data_out, dm_data_out, rd_out_mem, reg_write_out_mem,
        output mem_to_reg_out, stall_flag_mem_out, mem_busy, addr_err
    );

    modport master (
`ifdef DM_SUBWORD_ACCESS_EN
        output mem_size, load_unsigned,
`endif
        output stall_flag_mem_in, alu_result_in, store_data_in, rd_in_mem,
        output reg_write_in, mem_to_reg_in, mem_read, mem_write,
        input  alu_data_out, dm_data_out, rd_out_mem, reg_write_out_mem,
        input  mem_to_reg_out, stall_flag_mem_out, mem_busy, addr_err
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: data memory, load/store with MEM_LATENCY-cycle access and the MEM/WB register.
// Optional byte/halfword access is enabled by defining DM_SUBWORD_ACCESS_EN.
module mem_access #(
    parameter int DM_DEPTH    = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);
    localparam int AW = $clog2(DM_DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [31:0]   dmem [DM_DEPTH];
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word, load_val, store_word;
    logic          mem_op, misaligned, out_of_range, addr_bad;
    logic          do_access, bubble, do_store;

`ifdef DM_SUBWORD_ACCESS_EN
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] a,
                                                 input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] d,
                                                input logic [1:0] a, input logic [1:0] sz);
        logic [31:0] r;
        r = old;
        case (sz)
            2'b00:   r[{a, 3'b000} +: 8]      = d[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        case (bus.mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.alu_result_in[0];
            default: misaligned = |bus.alu_result_in[1:0];
        endcase
    end
    assign load_val   = load_extract(rd_word, bus.alu_result_in[1:0], bus.mem_size, bus.load_unsigned);
    assign store_word = store_merge(rd_word, bus.store_data_in, bus.alu_result_in[1:0], bus.mem_size);
`else
    assign misaligned = |bus.alu_result_in[1:0];
    assign load_val   = rd_word;
    assign store_word = bus.store_data_in;
`endif

    assign word_idx     = bus.alu_result_in[AW+1:2];
    assign out_of_range = {32'b0, bus.alu_result_in} >= 64'(DM_DEPTH) * 64'd4;
    assign addr_bad     = misaligned | out_of_range;
    assign mem_op       = bus.mem_read | bus.mem_write;
    assign rd_word      = dmem[word_idx];
    assign bus.mem_busy = (state == WAIT);
    // Reset gating keeps a store presented while reset is low from touching memory.
    assign do_store     = do_access & bus.mem_write & ~addr_bad & reset;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        bubble    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.stall_flag_mem_in) begin
                    if (mem_op && MEM_LATENCY > 1) begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(MEM_LATENCY - 1);
                        bubble    = 1'b1;
                    end else begin
                        do_access = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    do_access = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    bubble  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_store) dmem[word_idx] <= store_word;
    end

    // MEM/WB register boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= IDLE;
            cnt                    <= 4'd0;
            bus.alu_data_out       <= 32'b0;
            bus.dm_data_out        <= 32'b0;
            bus.rd_out_mem         <= 5'b0;
            bus.reg_write_out_mem  <= 1'b0;
            bus.mem_to_reg_out     <= 1'b0;
            bus.stall_flag_mem_out <= 1'b0;
            bus.addr_err           <= 1'b0;
        end else begin
            state                  <= state_nxt;
            cnt                    <= cnt_nxt;
            bus.stall_flag_mem_out <= bus.stall_flag_mem_in;
            bus.addr_err           <= 1'b0;
            if (do_access) begin
                bus.alu_data_out      <= bus.alu_result_in;
                bus.dm_data_out       <= (bus.mem_read && !bus.mem_write && !addr_bad) ? load_val : 32'b0;
                bus.rd_out_mem        <= bus.rd_in_mem;
                bus.reg_write_out_mem <= bus.reg_write_in;
                bus.mem_to_reg_out    <= bus.mem_to_reg_in;
                bus.addr_err          <= mem_op & addr_bad;
            end else if (bubble) begin
                bus.alu_data_out      <= bus.alu_result_in;
                bus.dm_data_out       <= 32'b0;
                bus.rd_out_mem        <= 5'b0;
                bus.reg_write_out_mem <= 1'b0;
                bus.mem_to_reg_out    <= 1'b0;
            end
        end
    end
endmodule
